// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control path: FSM states,
// opcodes, immediate/ALU/select codes and the op-only immediate-format lookup.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BRANCH, JAL, LUI, TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_IMMEXT    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  function automatic logic [2:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_LUI:    return IMM_U;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational ALU decoder: turns the FSM's alu_op plus funct3/funct7b5/op[5]
// into the 3-bit ALU control code.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       op5_i,
  output logic [2:0] alu_ctrl_o
);

  always_comb begin
    alu_ctrl_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_ADD: alu_ctrl_o = ALU_ADD;
      ALUOP_SUB: alu_ctrl_o = ALU_SUB;
      default: begin
        case (funct3_i)
          // op[5] distinguishes R-type from I-type, so addi never becomes sub
          3'b000:  alu_ctrl_o = (funct7b5_i && op5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_ctrl_o = ALU_SLT;
          3'b110:  alu_ctrl_o = ALU_OR;
          3'b111:  alu_ctrl_o = ALU_AND;
          default: alu_ctrl_o = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core. Define MEM_HANDSHAKE_EN to make
// memory states wait on mem_ready with a WAIT_TIMEOUT-bounded stall counter.
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       lt,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [2:0] alu_ctrl,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] imm_src,
  output logic       reg_write,
  output logic       trap,
  output logic [1:0] trap_cause
);

  state_t     state_q, state_d;
  logic [1:0] cause_q, cause_d;
  logic       rdy;
  logic       timeout;
  logic       br_taken, br_legal;
  logic [1:0] alu_op;
  logic       mem_req_c, pc_write_c, mem_write_c, ir_write_c, reg_write_c;

`ifdef MEM_HANDSHAKE_EN
  localparam int CNT_W = $clog2(WAIT_TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_state;

  assign rdy       = mem_ready;
  assign mem_state = (state_q == FETCH) || (state_q == MEMREAD) || (state_q == MEMWRITE);
  // Limit is checked one cycle after the last counted stall, so a late ready still wins
  assign timeout   = mem_state && !mem_ready && (cnt_q == CNT_W'(WAIT_TIMEOUT));

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)          cnt_d = '0;
    else if (mem_state && !mem_ready) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  logic unused_hs;

  assign rdy       = 1'b1;
  assign timeout   = 1'b0;
  assign unused_hs = mem_ready | (WAIT_TIMEOUT == 0);
`endif

  always_comb begin
    br_taken = 1'b0;
    br_legal = 1'b1;
    case (funct3)
      F3_BEQ:  br_taken = zero;
      F3_BNE:  br_taken = ~zero;
      F3_BLT:  br_taken = lt;
      F3_BGE:  br_taken = ~lt;
      default: br_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FETCH;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      FETCH: begin
        if (rdy) state_d = DECODE;
        else if (timeout) begin
          state_d = TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_RTYPE:          state_d = EXECR;
          OP_ITYPE:          state_d = EXECI;
          OP_BRANCH:         state_d = BRANCH;
          OP_JAL:            state_d = JAL;
          OP_LUI:            state_d = LUI;
          default: begin
            state_d = TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      MEMADR: state_d = (op == OP_STORE) ? MEMWRITE : MEMREAD;
      MEMREAD: begin
        if (rdy) state_d = MEMWB;
        else if (timeout) begin
          state_d = TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      MEMWB: state_d = FETCH;
      MEMWRITE: begin
        if (rdy) state_d = FETCH;
        else if (timeout) begin
          state_d = TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      EXECR, EXECI: state_d = ALUWB;
      ALUWB:        state_d = FETCH;
      BRANCH: begin
        if (br_legal) state_d = FETCH;
        else begin
          state_d = TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      JAL:     state_d = ALUWB;
      LUI:     state_d = FETCH;
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    mem_req_c   = 1'b0;
    pc_write_c  = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    adr_src     = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    alu_op      = ALUOP_ADD;
    case (state_q)
      FETCH: begin
        mem_req_c  = 1'b1;
        ir_write_c = rdy;
        pc_write_c = rdy;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
      end
      DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      MEMREAD: begin
        mem_req_c = 1'b1;
        adr_src   = 1'b1;
      end
      MEMWB: begin
        result_src  = RES_DATA;
        reg_write_c = 1'b1;
      end
      MEMWRITE: begin
        mem_req_c   = 1'b1;
        adr_src     = 1'b1;
        mem_write_c = 1'b1;
      end
      EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_FUNCT;
      end
      EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      ALUWB: reg_write_c = 1'b1;
      BRANCH: begin
        alu_src_a  = SRCA_RS1;
        alu_op     = ALUOP_SUB;
        pc_write_c = br_taken && br_legal;
      end
      JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        pc_write_c = 1'b1;
      end
      LUI: begin
        result_src  = RES_IMMEXT;
        reg_write_c = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset forces FETCH, whose enables would otherwise be live; mask them while reset is held
  assign mem_req    = mem_req_c   & reset_n;
  assign pc_write   = pc_write_c  & reset_n;
  assign mem_write  = mem_write_c & reset_n;
  assign ir_write   = ir_write_c  & reset_n;
  assign reg_write  = reg_write_c & reset_n;
  assign imm_src    = imm_src_of(op);
  assign trap       = (state_q == TRAP);
  assign trap_cause = cause_q;

  alu_decoder u_alu_decoder (
    .alu_op_i   (alu_op),
    .funct3_i   (funct3),
    .funct7b5_i (funct7b5),
    .op5_i      (op[5]),
    .alu_ctrl_o (alu_ctrl)
  );

endmodule
